cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/loader_pkg.sv | 20 ++
 rtl/cart_loader.sv | 126 ++++++++++++
 tb/tb_cart_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the cartridge loader: FSM state encoding, the default
// copy limit and the length clamp used when a download finishes.
package loader_pkg;

    localparam logic [15:0] DEFAULT_MAX_SIZE = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [15:0] clamp_len(input logic [15:0] sz, input logic [15:0] max_sz);
        return (sz > max_sz) ? max_sz : sz;
    endfunction

endpackage

// File: rtl/cart_loader.sv
// Copies a finished IO-controller download into cart memory one byte at a time
// (read, wait for registered RAM, write with handshake), holding the core in reset meanwhile.
module cart_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] MAX_SIZE  = DEFAULT_MAX_SIZE,
    parameter logic [14:0] CART_BASE = 15'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        downloading,
    input  logic [15:0] size,
    input  logic [14:0] cpu_a,
    output logic [14:0] buf_a,
    input  logic [7:0]  buf_dout,
    output logic [14:0] cart_a,
    output logic [7:0]  cart_din,
    output logic        cart_we,
    input  logic        cart_ready,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        oversize
);

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] len_q, len_d;
    logic [14:0] cart_a_q, cart_a_d;
    logic [7:0]  cart_din_q, cart_din_d;
    logic        cart_we_q, cart_we_d;
    logic        core_reset_q, core_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        oversize_q, oversize_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            len_q        <= '0;
            cart_a_q     <= CART_BASE;
            cart_din_q   <= '0;
            cart_we_q    <= 1'b0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            oversize_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            cart_a_q     <= cart_a_d;
            cart_din_q   <= cart_din_d;
            cart_we_q    <= cart_we_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            oversize_q   <= oversize_d;
        end
    end

    // A new download always wins, aborting any copy without a done pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        if (downloading) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    len_d   = clamp_len(size, MAX_SIZE);
                    ptr_d   = '0;
                    state_d = (len_d == 16'd0) ? ST_DONE : ST_READ;
                end
                ST_READ: state_d = ST_WAIT;
                ST_WAIT: state_d = ST_WRITE;
                ST_WRITE: begin
                    if (cart_ready) begin
                        ptr_d   = ptr_q + 16'd1;
                        state_d = (ptr_d == len_q) ? ST_DONE : ST_READ;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs are decoded from the upcoming state so they line up with it.
    always_comb begin
        cart_we_d    = (state_d == ST_WRITE);
        core_reset_d = (state_d == ST_LOAD) || (state_d == ST_READ) ||
                       (state_d == ST_WAIT) || (state_d == ST_WRITE);
        busy_d       = core_reset_d;
        done_d       = (state_d == ST_DONE);

        cart_din_d = cart_din_q;
        cart_a_d   = cart_a_q;
        if (state_q == ST_WAIT) begin
            cart_din_d = buf_dout;
            cart_a_d   = CART_BASE + ptr_q[14:0];
        end

        oversize_d = oversize_q;
        if (state_d == ST_LOAD) begin
            oversize_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            oversize_d = (size > MAX_SIZE);
        end
    end

    // The CPU only owns the buffer port while the loader is idle.
    assign buf_a = (state_q == ST_IDLE) ? cpu_a : ptr_q[14:0];

    assign cart_a     = cart_a_q;
    assign cart_din   = cart_din_q;
    assign cart_we    = cart_we_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign oversize   = oversize_q;

endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: two instances (default and wrapped base /
// small limit), table-driven copies, hand-written corner sequences, randomized copies.
module tb_cart_loader;

    localparam logic [15:0] MAX0  = 16'h8000;
    localparam logic [14:0] BASE0 = 15'h0000;
    localparam logic [15:0] MAX1  = 16'd20;
    localparam logic [14:0] BASE1 = 15'h7FFE;

    logic        clk;
    logic        reset;
    logic        dl;
    logic        sel;
    logic        cart_ready;
    logic [15:0] size;
    logic [14:0] cpu_a;
    logic [1:0]  dl_w;
    logic [14:0] buf_a0, buf_a1, cart_a0, cart_a1;
    logic [7:0]  buf_dout0, buf_dout1, cart_din0, cart_din1;
    logic [1:0]  cart_we_w, core_reset_w, busy_w, done_w, oversize_w;

    logic [7:0]  mem [0:32767];
    logic [22:0] wq0[$];
    logic [22:0] wq1[$];
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;
    int          checks    = 0;
    int          failures  = 0;

    assign dl_w = {dl & sel, dl & ~sel};

    cart_loader #(.MAX_SIZE(MAX0), .CART_BASE(BASE0)) dut0 (
        .clk(clk), .reset(reset), .downloading(dl_w[0]), .size(size), .cpu_a(cpu_a),
        .buf_a(buf_a0), .buf_dout(buf_dout0), .cart_a(cart_a0), .cart_din(cart_din0),
        .cart_we(cart_we_w[0]), .cart_ready(cart_ready), .core_reset(core_reset_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .oversize(oversize_w[0])
    );

    cart_loader #(.MAX_SIZE(MAX1), .CART_BASE(BASE1)) dut1 (
        .clk(clk), .reset(reset), .downloading(dl_w[1]), .size(size), .cpu_a(cpu_a),
        .buf_a(buf_a1), .buf_dout(buf_dout1), .cart_a(cart_a1), .cart_din(cart_din1),
        .cart_we(cart_we_w[1]), .cart_ready(cart_ready), .core_reset(core_reset_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .oversize(oversize_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered download buffer: data one clock after the address.
    always @(posedge clk) begin
        buf_dout0 <= mem[buf_a0];
        buf_dout1 <= mem[buf_a1];
    end

    // Inputs change 2 units after posedge, so negedge values are those the next edge sees.
    always @(negedge clk) begin
        if (!reset && cart_we_w[0] && cart_ready) wq0.push_back({cart_a0, cart_din0});
        if (!reset && cart_we_w[1] && cart_ready) wq1.push_back({cart_a1, cart_din1});
        if (done_w[0]) done_cnt0 <= done_cnt0 + 1;
        if (done_w[1]) done_cnt1 <= done_cnt1 + 1;
    end

    typedef struct {
        bit          d;
        logic [15:0] sz;
        int          exp_n;
        bit          exp_ov;
        logic [14:0] exp_first;
        logic [14:0] exp_last;
        int          exp_cyc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] max_of(input bit d);
        return d ? MAX1 : MAX0;
    endfunction

    function automatic logic [14:0] base_of(input bit d);
        return d ? BASE1 : BASE0;
    endfunction

    function automatic int wcount(input bit d);
        return d ? wq1.size() : wq0.size();
    endfunction

    function automatic logic [22:0] wget(input bit d, input int i);
        return d ? wq1[i] : wq0[i];
    endfunction

    function automatic int dcount(input bit d);
        return d ? done_cnt1 : done_cnt0;
    endfunction

    task automatic clear_q();
        wq0.delete();
        wq1.delete();
    endtask

    // Reference: byte i of the buffer lands at (base + i) mod 2^15, for i < min(size, max).
    task automatic check_copy(input bit d, input logic [15:0] sz);
        int n;
        n = (sz > max_of(d)) ? int'(max_of(d)) : int'(sz);
        check("model_write_count", wcount(d), n);
        for (int i = 0; i < n && i < wcount(d); i++) begin
            check("model_addr_data", 32'(wget(d, i)), 32'({15'(int'(base_of(d)) + i), mem[i]}));
        end
    endtask

    task automatic wait_done(input bit d, input int budget);
        int k;
        k = 0;
        while (!done_w[d] && k < budget) begin
            step();
            k++;
        end
        check("done_within_budget", done_w[d], 1);
        step();
    endtask

    task automatic run_copy(input bit d, input logic [15:0] sz, input bit rnd, output int cyc);
        int d0;
        clear_q();
        d0         = dcount(d);
        sel        = d;
        size       = sz;
        cart_ready = 1'b1;
        dl         = 1'b1;
        step();
        step();
        check("load_core_reset", core_reset_w[d], 1);
        check("load_busy", busy_w[d], 1);
        dl = 1'b0;
        step();
        cyc = 0;
        while (!done_w[d] && cyc < 5000) begin
            cart_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        check("done_seen", done_w[d], 1);
        cart_ready = 1'b1;
        step();
        check("done_one_cycle", done_w[d], 0);
        check("idle_core_reset", core_reset_w[d], 0);
        check("idle_busy", busy_w[d], 0);
        check("done_pulse_count", dcount(d) - d0, 1);
    endtask

    initial begin
        int          cyc;
        int          k;
        int          n;
        bit          d;
        logic [15:0] sz;

        vecs[0] = '{1'b0, 16'd4,    4,  1'b0, 15'h0000, 15'h0003, 12};
        vecs[1] = '{1'b0, 16'd0,    0,  1'b0, 15'h0000, 15'h0000, 0};
        vecs[2] = '{1'b0, 16'd1,    1,  1'b0, 15'h0000, 15'h0000, 3};
        vecs[3] = '{1'b1, 16'd4,    4,  1'b0, 15'h7FFE, 15'h0001, 12};
        vecs[4] = '{1'b1, 16'd0,    0,  1'b0, 15'h7FFE, 15'h7FFE, 0};
        vecs[5] = '{1'b1, 16'd20,   20, 1'b0, 15'h7FFE, 15'h0011, 60};
        vecs[6] = '{1'b1, 16'd21,   20, 1'b1, 15'h7FFE, 15'h0011, 60};
        vecs[7] = '{1'b1, 16'h9000, 20, 1'b1, 15'h7FFE, 15'h0011, 60};
        vecs[8] = '{1'b1, 16'hFFFF, 20, 1'b1, 15'h7FFE, 15'h0011, 60};
        vecs[9] = '{1'b0, 16'd40,   40, 1'b0, 15'h0000, 15'h0027, 120};

        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;

        reset      = 1'b1;
        dl         = 1'b0;
        sel        = 1'b0;
        size       = 16'd0;
        cpu_a      = 15'h1234;
        cart_ready = 1'b1;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_cart_a0", cart_a0, BASE0);
        check("rst_cart_a1", cart_a1, BASE1);
        check("rst_cart_din", {cart_din1, cart_din0}, 0);
        check("rst_cart_we", cart_we_w, 0);
        check("rst_core_reset", core_reset_w, 0);
        check("rst_done", done_w, 0);
        check("rst_oversize", oversize_w, 0);
        check("rst_busy", busy_w, 0);
        check("idle_buf_a_pass", buf_a0, 15'h1234);
        cpu_a = 15'h5A5A;
        #1;
        check("idle_buf_a_comb", buf_a1, 15'h5A5A);
        $display("reset checks done");

        // Table-driven copies with cart_ready tied high.
        for (int v = 0; v < NV; v++) begin
            run_copy(vecs[v].d, vecs[v].sz, 1'b0, cyc);
            check("copy_cycles", cyc, vecs[v].exp_cyc);
            check("tbl_write_count", wcount(vecs[v].d), vecs[v].exp_n);
            check("tbl_oversize", oversize_w[vecs[v].d], vecs[v].exp_ov);
            if (vecs[v].exp_n > 0 && wcount(vecs[v].d) > 0) begin
                check("tbl_first_addr", wget(vecs[v].d, 0) >> 8, vecs[v].exp_first);
                check("tbl_last_addr", wget(vecs[v].d, wcount(vecs[v].d) - 1) >> 8, vecs[v].exp_last);
            end
            check_copy(vecs[v].d, vecs[v].sz);
            $display("copy dut%0d size=%h writes=%0d cycles=%0d oversize=%0b",
                     vecs[v].d, vecs[v].sz, wcount(vecs[v].d), cyc, oversize_w[vecs[v].d]);
        end
        check("tbl_bytes_11_22_33_44", 32'(wq0.size()), 32'd40);

        // Stall on byte 1: everything on the cart port must hold for 5 cycles.
        clear_q();
        sel  = 1'b0;
        size = 16'd3;
        dl   = 1'b1;
        step();
        dl = 1'b0;
        step();
        k = 0;
        while (!(cart_we_w[0] && cart_a0 == 15'd1) && k < 50) begin
            step();
            k++;
        end
        check("stall_reached", 32'(cart_we_w[0] && cart_a0 == 15'd1), 1);
        cart_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_we", cart_we_w[0], 1);
            check("stall_a", cart_a0, 15'd1);
            check("stall_din", cart_din0, mem[1]);
        end
        cart_ready = 1'b1;
        wait_done(1'b0, 50);
        check("stall_total_writes", wcount(1'b0), 3);
        check_copy(1'b0, 16'd3);
        $display("stall copy writes=%0d", wcount(1'b0));

        // Oversize download aborted by a new download; restart copies from byte 0.
        clear_q();
        k    = dcount(1'b0);
        size = 16'h9000;
        dl   = 1'b1;
        step();
        dl = 1'b0;
        step();
        check("big_oversize_set", oversize_w[0], 1);
        n = 0;
        while (wcount(1'b0) < 2 && n < 50) begin
            step();
            n++;
        end
        dl = 1'b1;
        step();
        check("abort_cart_we", cart_we_w[0], 0);
        check("abort_core_reset", core_reset_w[0], 1);
        check("abort_busy", busy_w[0], 1);
        check("abort_oversize_clear", oversize_w[0], 0);
        step();
        step();
        check("abort_no_done", dcount(1'b0) - k, 0);
        clear_q();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        size = 16'd5;
        dl   = 1'b0;
        step();
        wait_done(1'b0, 100);
        check_copy(1'b0, 16'd5);
        check("restart_oversize", oversize_w[0], 0);
        $display("abort+restart writes=%0d", wcount(1'b0));

        // Reset during a stalled write.
        clear_q();
        size = 16'd4;
        dl   = 1'b1;
        step();
        dl         = 1'b0;
        cart_ready = 1'b0;
        step();
        k = 0;
        while (!cart_we_w[0] && k < 20) begin
            step();
            k++;
        end
        check("rst_mid_write_reached", cart_we_w[0], 1);
        reset = 1'b1;
        step();
        check("rst_mid_cart_we", cart_we_w[0], 0);
        check("rst_mid_core_reset", core_reset_w[0], 0);
        check("rst_mid_busy", busy_w[0], 0);
        check("rst_mid_done", done_w[0], 0);
        cpu_a = 15'h0777;
        #1;
        check("rst_mid_buf_a", buf_a0, 15'h0777);
        dl = 1'b1;
        step();
        check("rst_beats_download", busy_w[0], 0);
        reset      = 1'b0;
        cart_ready = 1'b1;
        size       = 16'd0;
        step();
        check("post_rst_load", busy_w[0], 1);
        dl = 1'b0;
        wait_done(1'b0, 20);
        check("rst_no_writes", wcount(1'b0), 0);
        $display("reset mid-write sequence done");

        // Randomized copies with random back-pressure.
        for (int r = 0; r < 12; r++) begin
            d  = 1'($urandom_range(0, 1));
            sz = d ? 16'($urandom_range(0, 30)) : 16'($urandom_range(0, 50));
            if (r == 5) sz = 16'hFFFF;
            if (d == 1'b0 && sz > 16'd50) sz = 16'd50;
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            run_copy(d, sz, 1'b1, cyc);
            check_copy(d, sz);
            check("rand_oversize", oversize_w[d], (sz > max_of(d)) ? 1 : 0);
            $display("random copy dut%0d size=%h writes=%0d cycles=%0d", d, sz, wcount(d), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
